// File: rtl/divider_pkg.sv
// ---------------------------------------------------------------------------
// divider_pkg
// Shared types and constants for the repeated-subtraction divider:
// default operand width, FSM state encoding and the result record that is
// also used by scoreboards.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package divider_pkg;

   localparam int DIV_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   typedef struct packed {
      logic [DIV_WIDTH-1:0] quotient;
      logic [DIV_WIDTH-1:0] remainder;
      logic                 div_by_zero;
   } div_result_t;

endpackage : divider_pkg

`default_nettype wire

// File: rtl/divider_if.sv
// ---------------------------------------------------------------------------
// divider_if
// Bundle of all divider ports except clock and reset, with a DUT-side and a
// testbench-side modport.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface divider_if
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport dut_mp (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

   modport tb_mp (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

endinterface : divider_if

`default_nettype wire

// File: rtl/divider_step.sv
// ---------------------------------------------------------------------------
// divider_step
// Combinational datapath for one subtraction step: compares the running
// remainder against the divisor and prepares the next remainder/quotient.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divider_step
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_div,
   input  logic [WIDTH-1:0] i_quo,
   output logic             o_ge,
   output logic [WIDTH-1:0] o_rem_next,
   output logic [WIDTH-1:0] o_quo_next
);

   // The subtract result is only consumed when o_ge is set, so it never
   // underflows where it matters; the quotient never exceeds 2^WIDTH-1.
   assign o_ge       = (i_rem >= i_div);
   assign o_rem_next = i_rem - i_div;
   assign o_quo_next = i_quo + WIDTH'(1);

endmodule : divider_step

`default_nettype wire

// File: rtl/divider.sv
// ---------------------------------------------------------------------------
// divider
// Unsigned divider by repeated subtraction with a start/done handshake.
// One subtraction per clock; quotient/remainder/div_by_zero are registered
// and hold until the next accepted start or reset.
// Optional macro: DIVIDER_UNIT_SHORTCUT_EN -- a divisor of 1 completes on
// the first edge after acceptance instead of walking the subtract loop.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module divider
   import divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_e       r_state;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;

   logic             w_ge;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_quo_next;

   divider_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem      (r_rem),
      .i_div      (r_div),
      .i_quo      (r_quo),
      .o_ge       (w_ge),
      .o_rem_next (w_rem_next),
      .o_quo_next (w_quo_next)
   );

   // Control FSM and result registers. Divide-by-zero (and the optional
   // unit-divisor shortcut) resolve on the first edge in SUB, which makes
   // them complete one edge after acceptance just like a zero quotient.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_div       <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_div       <= divisor;
                  r_rem       <= dividend;
                  r_quo       <= '0;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  r_state     <= SUB;
               end
            end
            SUB: begin
               if (r_div == '0) begin
                  quotient    <= '1;
                  remainder   <= r_rem;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  r_state     <= DONE;
`ifdef DIVIDER_UNIT_SHORTCUT_EN
               end else if (r_div == WIDTH'(1)) begin
                  quotient    <= r_rem;
                  remainder   <= '0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  r_state     <= DONE;
`endif
               end else if (w_ge) begin
                  r_rem <= w_rem_next;
                  r_quo <= w_quo_next;
               end else begin
                  quotient  <= r_quo;
                  remainder <= r_rem;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : divider

`default_nettype wire

// File: tb/tb_divider.sv
// ---------------------------------------------------------------------------
// tb_divider
// Self-checking bench for divider: table of directed vectors, hand-written
// corner sequences (ignored start, mid-operation reset) and a shuffled sweep
// of every WIDTH=4 operand pair, all checked through a scoreboard queue.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_divider;
   import divider_pkg::*;

   localparam int W = DIV_WIDTH;
`ifdef DIVIDER_UNIT_SHORTCUT_EN
   localparam bit SHORTCUT = 1'b1;
`else
   localparam bit SHORTCUT = 1'b0;
`endif

   typedef struct {
      div_result_t res;
      int          lat;
      int          e0;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      div_result_t  res;
      int           lat;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   divider_if #(.WIDTH(W)) bus ();

   divider #(.WIDTH(W)) dut (
      .clock       (clk),
      .reset       (rst_n),
      .start       (bus.start),
      .dividend    (bus.dividend),
      .divisor     (bus.divisor),
      .busy        (bus.busy),
      .done        (bus.done),
      .quotient    (bus.quotient),
      .remainder   (bus.remainder),
      .div_by_zero (bus.div_by_zero)
   );

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   busy_cnt = 0;
   bit   prev_done = 1'b0;
   exp_t sb[$];

   // Free-running clock and edge counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.e0 = 0;
      if (b == 0) begin
         e.res = '{quotient: '1, remainder: a, div_by_zero: 1'b1};
         e.lat = 1;
      end else begin
         e.res = '{quotient: W'(a / b), remainder: W'(a % b), div_by_zero: 1'b0};
         e.lat = (b == 1 && SHORTCUT) ? 1 : int'(a / b) + 1;
      end
      return e;
   endfunction

   // Monitor: samples 1 time unit after each edge and scores completions
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            busy_cnt  = 0;
            prev_done = 1'b0;
         end else begin
            if (prev_done) check("done_one_cycle", 32'(bus.done), 32'd0);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("quotient",    32'(bus.quotient),    32'(e.res.quotient));
                  check("remainder",   32'(bus.remainder),   32'(e.res.remainder));
                  check("div_by_zero", 32'(bus.div_by_zero), 32'(e.res.div_by_zero));
                  check("busy_at_done", 32'(bus.busy), 32'd0);
                  check("latency",     32'(cyc - e.e0),      32'(e.lat));
                  check("busy_cycles", 32'(busy_cnt),        32'(e.lat));
               end
               busy_cnt = 0;
            end
            prev_done = bus.done;
         end
      end
   end

   // Drive one request, push its expectation once the accepting edge passes
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input div_result_t r, input int lat);
      exp_t e;
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1;
      e.res = r;
      e.lat = lat;
      e.e0  = cyc;
      sb.push_back(e);
      bus.start    = 1'b0;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
   endtask

   // Wait (bounded) for the scoreboard to drain, then let DONE return to IDLE
   task automatic wait_done();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout actual=pending required=done (t=%0t)", $time);
         sb.delete();
      end
      @(posedge clk);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input div_result_t r, input int lat);
      start_op(a, b, r, lat);
      wait_done();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},        32'(bus.busy),        32'd0);
      check({tag, "_done"},        32'(bus.done),        32'd0);
      check({tag, "_quotient"},    32'(bus.quotient),    32'd0);
      check({tag, "_remainder"},   32'(bus.remainder),   32'd0);
      check({tag, "_div_by_zero"}, 32'(bus.div_by_zero), 32'd0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[9];
      int   order[256];
      int   tmp;
      int   j;
      exp_t m;

      vecs[0] = '{4'd13, 4'd4, '{4'd3,  4'd1, 1'b0}, 4};
      vecs[1] = '{4'd9,  4'd0, '{4'd15, 4'd9, 1'b1}, 1};
      vecs[2] = '{4'd3,  4'd7, '{4'd0,  4'd3, 1'b0}, 1};
      vecs[3] = '{4'd15, 4'd1, '{4'd15, 4'd0, 1'b0}, SHORTCUT ? 1 : 16};
      vecs[4] = '{4'd0,  4'd5, '{4'd0,  4'd0, 1'b0}, 1};
      vecs[5] = '{4'd7,  4'd7, '{4'd1,  4'd0, 1'b0}, 2};
      vecs[6] = '{4'd0,  4'd0, '{4'd15, 4'd0, 1'b1}, 1};
      vecs[7] = '{4'd14, 4'd3, '{4'd4,  4'd2, 1'b0}, 5};
      vecs[8] = '{4'd1,  4'd1, '{4'd1,  4'd0, 1'b0}, SHORTCUT ? 1 : 2};

      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("idle");

      // Directed table
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
      end

      // A start pulse with new operands mid-operation must be ignored
      start_op(4'd12, 4'd3, '{4'd4, 4'd0, 1'b0}, 5);
      repeat (2) @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 4'd6;
      bus.divisor  = 4'd2;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done();
      repeat (3) @(negedge clk);
      check("hold_quotient",    32'(bus.quotient),    32'd4);
      check("hold_remainder",   32'(bus.remainder),   32'd0);
      check("hold_div_by_zero", 32'(bus.div_by_zero), 32'd0);
      check("hold_busy",        32'(bus.busy),        32'd0);

      // Reset two cycles into 15/2: immediate clear, no completion
      start_op(4'd15, 4'd2, '{4'd7, 4'd1, 1'b0}, 8);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check_all_zero("abort");
      repeat (3) @(negedge clk);
      check_all_zero("abort_held");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("post_abort_done", 32'(bus.done), 32'd0);
      run_op(4'd8, 4'd2, '{4'd4, 4'd0, 1'b0}, 5);

      // Every operand pair, in shuffled order
      for (int i = 0; i < 256; i++) order[i] = i;
      for (int i = 255; i > 0; i--) begin
         j = int'($urandom_range(i, 0));
         tmp = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 256; i++) begin
         m = model(W'(order[i] >> W), W'(order[i]));
         run_op(W'(order[i] >> W), W'(order[i]), m.res, m.lat);
      end

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_divider

`default_nettype wire
